// File: rtl/multiplicador_secuencial.sv
// rtl/multiplicador_secuencial.sv - signed radix-2 Booth multiplier, one partial-product step per clock
module multiplicador_secuencial #(
  parameter int ANCHO = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic [ANCHO-1:0]     multiplicando,
  input  logic [ANCHO-1:0]     multiplicador,
  output logic [2*ANCHO-1:0]   producto,
  output logic                 ocupado,
  output logic                 listo
);

  localparam int              CW     = (ANCHO > 1) ? $clog2(ANCHO) : 1;
  localparam logic [CW-1:0]   ULTIMO = CW'(ANCHO - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       estado;
  logic [CW-1:0]    contador;
  logic [ANCHO:0]   acumulador;
  logic [ANCHO-1:0] q;
  logic             q_menos1;
  logic [ANCHO-1:0] a_reg;

  logic [ANCHO:0]   a_ext;
  logic [ANCHO:0]   suma;

  // One extra accumulator bit so that subtracting the most-negative A cannot overflow.
  always_comb begin
    a_ext = {a_reg[ANCHO-1], a_reg};
    case ({q[0], q_menos1})
      2'b01:   suma = acumulador + a_ext;
      2'b10:   suma = acumulador - a_ext;
      default: suma = acumulador;
    endcase
  end

  assign ocupado = (estado == CALC) || (estado == FIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= IDLE;
      contador   <= '0;
      acumulador <= '0;
      q          <= '0;
      q_menos1   <= 1'b0;
      a_reg      <= '0;
      producto   <= '0;
      listo      <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (estado)
        IDLE: begin
          if (iniciar) begin
            a_reg      <= multiplicando;
            q          <= multiplicador;
            q_menos1   <= 1'b0;
            acumulador <= '0;
            contador   <= '0;
            estado     <= CALC;
          end
        end
        CALC: begin
          // Arithmetic shift of {acumulador, q, q_menos1} right by one.
          acumulador <= {suma[ANCHO], suma[ANCHO:1]};
          q          <= {suma[0], q[ANCHO-1:1]};
          q_menos1   <= q[0];
          contador   <= contador + CW'(1);
          if (contador == ULTIMO) begin
            estado <= FIN;
          end
        end
        FIN: begin
          producto <= {acumulador[ANCHO-1:0], q};
          listo    <= 1'b1;
          estado   <= IDLE;
        end
        default: begin
          estado <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// tb/tb_multiplicador_secuencial.sv - directed self-checking bench for multiplicador_secuencial
module tb_multiplicador_secuencial;

  logic        clk;
  logic        reset;
  logic        iniciar;
  logic [7:0]  multiplicando;
  logic [7:0]  multiplicador;
  logic [15:0] producto;
  logic        ocupado;
  logic        listo;

  int n_comp;
  int n_err;

  multiplicador_secuencial #(.ANCHO(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .iniciar       (iniciar),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .producto      (producto),
    .ocupado       (ocupado),
    .listo         (listo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_comp++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic ejecutar(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] esp);
    int lat;
    bit hallado;
    @(negedge clk);
    multiplicando = a;
    multiplicador = b;
    iniciar       = 1'b1;
    @(posedge clk);
    #1;
    iniciar = 1'b0;
    comprobar({tag, " ocupado_tras_inicio"}, 32'(ocupado), 32'd1);
    lat     = 0;
    hallado = 1'b0;
    for (int i = 1; i <= 20 && !hallado; i++) begin
      @(posedge clk);
      #1;
      if (listo) begin
        hallado = 1'b1;
        lat     = i;
      end
    end
    comprobar({tag, " latencia"}, 32'(lat), 32'd9);
    comprobar({tag, " producto"}, 32'(producto), 32'(esp));
    comprobar({tag, " ocupado_en_listo"}, 32'(ocupado), 32'd0);
    @(posedge clk);
    #1;
    comprobar({tag, " listo_un_ciclo"}, 32'(listo), 32'd0);
    comprobar({tag, " producto_retenido"}, 32'(producto), 32'(esp));
  endtask

  initial begin
    int n_listo;
    int e_listo;
    int e1;
    int e2;
    logic [15:0] p1;
    logic [15:0] p2;

    n_comp        = 0;
    n_err         = 0;
    reset         = 1'b0;
    iniciar       = 1'b0;
    multiplicando = 8'd0;
    multiplicador = 8'd0;

    // Reset takes effect before any clock edge.
    #1 reset = 1'b1;
    #1;
    comprobar("reset producto", 32'(producto), 32'h0000);
    comprobar("reset listo", 32'(listo), 32'd0);
    comprobar("reset ocupado", 32'(ocupado), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    comprobar("idle sin iniciar", 32'(ocupado), 32'd0);

    ejecutar("7x-3",      8'd7,   8'hFD, 16'hFFEB);
    ejecutar("-5x-6",     8'hFB,  8'hFA, 16'h001E);
    ejecutar("-128x-128", 8'h80,  8'h80, 16'h4000);
    ejecutar("127x127",   8'h7F,  8'h7F, 16'h3F01);
    ejecutar("-128x127",  8'h80,  8'h7F, 16'hC080);
    ejecutar("0x-77",     8'd0,   8'hB3, 16'h0000);

    // Start while busy: second request at edge 4 must be dropped.
    @(negedge clk);
    multiplicando = 8'd3;
    multiplicador = 8'd4;
    iniciar       = 1'b1;
    @(posedge clk);
    #1;
    iniciar = 1'b0;
    n_listo = 0;
    e_listo = 0;
    for (int e = 1; e <= 25; e++) begin
      if (e == 4) begin
        multiplicando = 8'd9;
        multiplicador = 8'd9;
        iniciar       = 1'b1;
      end
      @(posedge clk);
      #1;
      if (e == 4) iniciar = 1'b0;
      if (listo) begin
        n_listo++;
        if (e_listo == 0) e_listo = e;
      end
    end
    comprobar("ocupado n_listo", 32'(n_listo), 32'd1);
    comprobar("ocupado flanco_listo", 32'(e_listo), 32'd9);
    comprobar("ocupado producto", 32'(producto), 32'h000C);

    // Back-to-back with iniciar held high.
    @(negedge clk);
    multiplicando = 8'd2;
    multiplicador = 8'd3;
    iniciar       = 1'b1;
    @(posedge clk);
    #1;
    multiplicando = 8'hFF;
    multiplicador = 8'd1;
    n_listo = 0;
    e1 = 0;
    e2 = 0;
    p1 = '0;
    p2 = '0;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk);
      #1;
      if (listo) begin
        n_listo++;
        if (n_listo == 1) begin
          e1 = e;
          p1 = producto;
        end else if (n_listo == 2) begin
          e2 = e;
          p2 = producto;
        end
      end
      if (e == 14) comprobar("b2b producto_entre_pulsos", 32'(producto), 32'h0006);
      if (e == 19) iniciar = 1'b0;
    end
    comprobar("b2b n_listo", 32'(n_listo), 32'd2);
    comprobar("b2b flanco1", 32'(e1), 32'd9);
    comprobar("b2b producto1", 32'(p1), 32'h0006);
    comprobar("b2b flanco2", 32'(e2), 32'd19);
    comprobar("b2b producto2", 32'(p2), 32'hFFFF);

    // Abort: reset during CALC clears outputs immediately.
    @(negedge clk);
    multiplicando = 8'd10;
    multiplicador = 8'd10;
    iniciar       = 1'b1;
    @(posedge clk);
    #1;
    iniciar = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    comprobar("abort ocupado_antes", 32'(ocupado), 32'd1);
    reset = 1'b1;
    #1;
    comprobar("abort producto", 32'(producto), 32'h0000);
    comprobar("abort ocupado", 32'(ocupado), 32'd0);
    comprobar("abort listo", 32'(listo), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_listo = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk);
      #1;
      if (listo) n_listo++;
    end
    comprobar("abort sin_listo", 32'(n_listo), 32'd0);
    comprobar("abort idle", 32'(ocupado), 32'd0);
    ejecutar("1x1", 8'd1, 8'd1, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
    $finish;
  end

endmodule

// File: doc/multiplicador_secuencial.md
# multiplicador_secuencial

Signed fixed-point multiplier using iterative radix-2 Booth recoding (one partial-product step per clock). It sits directly upstream of the double-width saturating adder in the filter/accumulation datapath. It takes two `ANCHO`-bit two's-complement operands and delivers a full-precision `2*ANCHO`-bit signed product, which the adder consumes as one of its operands. With `ANCHO` = `ancho` from `constantes.h`, the product width equals `dobleancho`.

## Interface
Parameters:
- `ANCHO`, default 8: operand width in bits. Product width is `2*ANCHO`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `iniciar`  in  1  start request; sampled only in state IDLE.
- `multiplicando`  in  ANCHO  signed operand A; captured when a start is accepted.
- `multiplicador`  in  ANCHO  signed operand B; captured when a start is accepted.
- `producto`  out  2*ANCHO  signed A×B; registered; holds its value until the next result is written.
- `ocupado`  out  1  high while an operation is in progress (states CALC and FIN).
- `listo`  out  1  one-cycle pulse; high in the cycle where a new `producto` is first valid.

## Operation
- Reset (asynchronous, any state): state=IDLE, `producto`=0, `listo`=0, `ocupado`=0, iteration counter=0, internal accumulator cleared. Any operation in flight is aborted and produces no `listo`.
- State IDLE:
  - `iniciar`=1 at an edge: capture both operands, clear the accumulator, set counter=0, go to CALC, `ocupado`→1.
  - Otherwise: stay in IDLE.
- State CALC: each edge performs one Booth step.
  - The step examines multiplier bit pair {q0, q−1}: 01 adds A, 10 subtracts A, 00/11 adds nothing.
  - The step then arithmetic-shifts the combined {accumulator, Q, q−1} right by one.
  - Counter increments each step. The edge that completes step `ANCHO` (counter = `ANCHO`−1) moves to FIN.
- State FIN: at the next edge, write {accumulator, Q} to `producto`, pulse `listo`=1, drop `ocupado`→0, go to IDLE.
- `iniciar` is ignored while `ocupado`=1. Such a request is not queued.
- Operand changes after capture have no effect on the operation in flight.
- Width rules:
  - The accumulator is `ANCHO`+1 bits, so that subtracting the most-negative A cannot overflow.
  - The result is the exact two's-complement product. No saturation or rounding is done here; saturation belongs to the downstream adder.
  - Full-range check: (−2^(ANCHO−1))² = 2^(2ANCHO−2) fits in `2*ANCHO` signed bits.
- `producto` does not change except on the FIN edge or on reset.

## Timing
- Call the edge that samples `iniciar`=1 in IDLE edge 0.
- `ocupado` is high after edge 0 through edge `ANCHO`+1.
- `producto` and `listo` update at edge `ANCHO`+1, giving a latency of `ANCHO`+1 cycles (9 cycles for `ANCHO`=8).
- `listo` is high for exactly one cycle, which is the cycle following edge `ANCHO`+1. It falls at edge `ANCHO`+2.
- During the `listo` cycle the state is IDLE. If `iniciar`=1 in that cycle, it is accepted at edge `ANCHO`+2, so back-to-back throughput is one product per `ANCHO`+2 cycles.
- If `iniciar` is held high continuously, a new operation starts at every IDLE cycle.
- Reset asserted during CALC or FIN clears all outputs immediately, without waiting for a clock edge. After reset is released, the block stays idle until `iniciar` is sampled high.

## Test plan
All scenarios use `ANCHO`=8.
- Reset: assert `reset` with no clock edge → `producto`=0x0000, `listo`=0, `ocupado`=0 immediately.
- Basic signs:
  - A=7, B=−3, pulse `iniciar` → after 9 edges `producto`=0xFFEB (−21), with `listo` high for one cycle.
  - A=−5, B=−6 → 0x001E.
- Corners:
  - (−128)×(−128) → 0x4000.
  - 127×127 → 0x3F01.
  - (−128)×127 → 0xC080.
  - 0×(−77) → 0x0000.
- Start while busy: start 3×4, then pulse `iniciar` with 9×9 at edge 4 → only one `listo` occurs, `producto`=0x000C, and the second request produces nothing.
- Back-to-back: hold `iniciar`=1, with A=2, B=3 for the first operation and then A=−1, B=1 → `listo` at edges 9 and 19, producing 0x0006 then 0xFFFF. `producto` holds 0x0006 between those two `listo` pulses.
- Abort: start 10×10, assert `reset` at edge 5 → outputs clear at once and no `listo` occurs. After release, 1×1 produces 0x0001 with the normal 9-cycle latency.
